// File: rtl/prefetch_queue.sv
// -----------------------------------------------------------------------------
// prefetch_queue
//
// Instruction prefetch byte queue sitting between the I-cache and the decoder.
// Bundles of BUNDLE_BYTES bytes are requested in address order, written into a
// circular byte buffer of CAP = DEPTH*BUNDLE_BYTES entries, and up to
// PEEK_BYTES head bytes are presented to the decoder each cycle.
//
// Optional feature macro: PFQ_BYPASS_EN
//   defined   -> a bundle accepted into an empty queue is visible on peek_o /
//                peek_cnt_o in the same cycle and may be consumed at once.
//   undefined -> written bytes appear one cycle after acceptance; peek_o is
//                driven only from stored state.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          synchronous reset, active-low
//   fetch_req_o    request the bundle at fetch_adr_o
//   fetch_adr_o    BUNDLE_BYTES-aligned address of the requested bundle
//   bundle_vld_i   bundle present on bundle_i
//   bundle_adr_i   aligned address of bundle_i
//   bundle_i       bundle data, byte 0 in bits [7:0]
//   peek_o         head bytes, head byte in bits [7:0], NOP (8'h90) filler
//   peek_cnt_o     number of valid bytes on peek_o
//   head_adr_o     linear address of the head byte
//   consume_i      decoder consumes consume_cnt_i bytes this cycle
//   consume_cnt_i  number of bytes consumed
//   flush_i        redirect: discard contents, restart at flush_adr_i
//   flush_adr_i    new head address
//   err_o          one-cycle pulse after an over-consume
// -----------------------------------------------------------------------------
module prefetch_queue #(
  parameter int BUNDLE_BYTES = 16,
  parameter int DEPTH        = 4,
  parameter int PEEK_BYTES   = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  output logic                              fetch_req_o,
  output logic [31:0]                       fetch_adr_o,
  input  logic                              bundle_vld_i,
  input  logic [31:0]                       bundle_adr_i,
  input  logic [BUNDLE_BYTES*8-1:0]         bundle_i,
  output logic [PEEK_BYTES*8-1:0]           peek_o,
  output logic [$clog2(PEEK_BYTES+1)-1:0]   peek_cnt_o,
  output logic [31:0]                       head_adr_o,
  input  logic                              consume_i,
  input  logic [$clog2(PEEK_BYTES+1)-1:0]   consume_cnt_i,
  input  logic                              flush_i,
  input  logic [31:0]                       flush_adr_i,
  output logic                              err_o
);

  localparam int CAP = DEPTH * BUNDLE_BYTES;
  localparam int PW  = $clog2(CAP);            // buffer pointer width
  localparam int CW  = PW + 1;                 // byte count 0..CAP
  localparam int OW  = $clog2(BUNDLE_BYTES);   // byte offset inside a bundle
  localparam int BW  = OW + 1;                 // bytes written 0..BUNDLE_BYTES
  localparam int KW  = $clog2(PEEK_BYTES + 1); // peek / consume count

  localparam logic [31:0]   ALIGN_MASK = ~(32'(BUNDLE_BYTES) - 32'd1);
  localparam logic [31:0]   RST_HEAD   = 32'hFFFF_FFF0;
  localparam logic [31:0]   RST_FETCH  = RST_HEAD & ALIGN_MASK;
  localparam logic [CW-1:0] CAP_C      = CW'(CAP);
  localparam logic [CW-1:0] BUNDLE_C   = CW'(BUNDLE_BYTES);
  localparam logic [KW-1:0] PEEK_C     = KW'(PEEK_BYTES);
  localparam logic [7:0]    NOP_BYTE   = 8'h90;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [CAP];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       fetch_adr_q, fetch_adr_d;
  logic [31:0]       head_adr_q, head_adr_d;
  logic              fetch_req_q;
  logic              err_q;

  logic              accept_s;
  logic [OW-1:0]     wr_off_s;
  logic [BW-1:0]     wr_bytes_s;
  logic              wr_en_s  [BUNDLE_BYTES];
  logic [PW-1:0]     wr_idx_s [BUNDLE_BYTES];
  logic [KW-1:0]     buf_cnt_s;
  logic [PEEK_BYTES*8-1:0] buf_peek_s;
  logic [KW-1:0]     peek_cnt_s;
  logic [PEEK_BYTES*8-1:0] peek_s;
  logic [KW-1:0]     cons_s;
  logic              over_s;

  // A single request is outstanding at a time: fetch_adr_q only moves when
  // its bundle lands, so there are never in-flight bytes beyond the space
  // check below. fetch_req_q already encodes "CAP - count >= BUNDLE_BYTES"
  // for the current (pre-consume) count, so it also gates acceptance.
  assign accept_s = bundle_vld_i && (bundle_adr_i == fetch_adr_q) &&
                    fetch_req_q && !flush_i;

  // ---------------------------------------------------------------------------
  // FSM: RUN / REFILL
  // ---------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_REFILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: flush restarts refill, first accepted bundle resumes RUN
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_REFILL;
    end else begin
      case (state_q)
        ST_REFILL: state_d = accept_s ? ST_RUN : ST_REFILL;
        ST_RUN:    state_d = ST_RUN;
        default:   state_d = ST_REFILL;
      endcase
    end
  end

  // State outputs: in REFILL the head may sit mid-bundle, skip bytes below it
  always_comb begin
    wr_off_s = {OW{1'b0}};
    case (state_q)
      ST_REFILL: wr_off_s = head_adr_q[OW-1:0];
      ST_RUN:    wr_off_s = {OW{1'b0}};
      default:   wr_off_s = {OW{1'b0}};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------

  // Number of bytes written and per-byte buffer slot for an accepted bundle
  always_comb begin
    if (accept_s) begin
      wr_bytes_s = BW'(BUNDLE_BYTES) - BW'(wr_off_s);
    end else begin
      wr_bytes_s = {BW{1'b0}};
    end
    for (int i = 0; i < BUNDLE_BYTES; i++) begin
      wr_en_s[i]  = accept_s && (i >= int'(wr_off_s));
      wr_idx_s[i] = tail_q + PW'(i) - PW'(wr_off_s);
    end
  end

  // Byte storage; occupancy lives in count_q so the array needs no reset
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < BUNDLE_BYTES; i++) begin
      if (wr_en_s[i]) begin
        mem_q[wr_idx_s[i]] <= bundle_i[i*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------

  // Stored head bytes with NOP filler above min(count, PEEK_BYTES)
  always_comb begin
    if (count_q >= CW'(PEEK_BYTES)) begin
      buf_cnt_s = PEEK_C;
    end else begin
      buf_cnt_s = KW'(count_q);
    end
    for (int j = 0; j < PEEK_BYTES; j++) begin
      if (j < int'(buf_cnt_s)) begin
        buf_peek_s[j*8 +: 8] = mem_q[head_q + PW'(j)];
      end else begin
        buf_peek_s[j*8 +: 8] = NOP_BYTE;
      end
    end
  end

`ifdef PFQ_BYPASS_EN
  logic                    byp_s;
  logic [BUNDLE_BYTES*8-1:0] byp_bytes_s;
  logic [KW-1:0]           byp_cnt_s;
  logic [PEEK_BYTES*8-1:0] byp_peek_s;

  // An empty queue has head == tail, so the bypassed bytes are exactly the
  // ones being written at the head slot this cycle.
  assign byp_s       = accept_s && (count_q == {CW{1'b0}});
  assign byp_bytes_s = bundle_i >> {wr_off_s, 3'b000};

  // Peek view of the incoming bundle for the empty-queue bypass
  always_comb begin
    if (wr_bytes_s >= BW'(PEEK_BYTES)) begin
      byp_cnt_s = PEEK_C;
    end else begin
      byp_cnt_s = KW'(wr_bytes_s);
    end
    for (int j = 0; j < PEEK_BYTES; j++) begin
      if (j < int'(byp_cnt_s)) begin
        byp_peek_s[j*8 +: 8] = byp_bytes_s[j*8 +: 8];
      end else begin
        byp_peek_s[j*8 +: 8] = NOP_BYTE;
      end
    end
  end

  // Select bypass view while the queue is empty and a bundle lands
  always_comb begin
    if (byp_s) begin
      peek_cnt_s = byp_cnt_s;
      peek_s     = byp_peek_s;
    end else begin
      peek_cnt_s = buf_cnt_s;
      peek_s     = buf_peek_s;
    end
  end
`else
  assign peek_cnt_s = buf_cnt_s;
  assign peek_s     = buf_peek_s;
`endif

  // Consume amount clipped to what is visible; excess flags an error
  always_comb begin
    if (consume_i && !flush_i) begin
      if (consume_cnt_i > peek_cnt_s) begin
        cons_s = peek_cnt_s;
        over_s = 1'b1;
      end else begin
        cons_s = consume_cnt_i;
        over_s = 1'b0;
      end
    end else begin
      cons_s = {KW{1'b0}};
      over_s = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, count and addresses
  // ---------------------------------------------------------------------------

  // Next-state values; flush discards everything else in its cycle
  always_comb begin
    if (flush_i) begin
      head_d      = {PW{1'b0}};
      tail_d      = {PW{1'b0}};
      count_d     = {CW{1'b0}};
      head_adr_d  = flush_adr_i;
      fetch_adr_d = flush_adr_i & ALIGN_MASK;
    end else begin
      head_d      = head_q + PW'(cons_s);
      tail_d      = tail_q + PW'(wr_bytes_s);
      count_d     = count_q + CW'(wr_bytes_s) - CW'(cons_s);
      head_adr_d  = head_adr_q + 32'(cons_s);
      if (accept_s) begin
        fetch_adr_d = fetch_adr_q + 32'(BUNDLE_BYTES);
      end else begin
        fetch_adr_d = fetch_adr_q;
      end
    end
  end

  // Datapath registers; fetch_req_q holds the space check for the new count
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head_q      <= {PW{1'b0}};
      tail_q      <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      fetch_adr_q <= RST_FETCH;
      head_adr_q  <= RST_HEAD;
      fetch_req_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fetch_adr_q <= fetch_adr_d;
      head_adr_q  <= head_adr_d;
      fetch_req_q <= ((CAP_C - count_d) >= BUNDLE_C);
      err_q       <= over_s;
    end
  end

  assign fetch_req_o = fetch_req_q;
  assign fetch_adr_o = fetch_adr_q;
  assign head_adr_o  = head_adr_q;
  assign err_o       = err_q;
  assign peek_cnt_o  = peek_cnt_s;
  assign peek_o      = peek_s;

endmodule
